// File: rtl/irq_ctrl_if.sv
// Register-bus and interrupt-line bundle between the CPU side and irq_ctrl.
// Latency: none; this file only declares wires.
// Backpressure: none; the controller answers every access one cycle later.
interface irq_ctrl_if #(
  parameter int NSRC = 4
);

  // Peripheral interrupt request lines (source 0 is the timer)
  logic [NSRC-1:0] src;

  // Memory-mapped register access
  logic [1:0]  a;
  logic [31:0] d;
  logic        we;
  logic        rd;
  logic [31:0] spo;
  logic        ready;

  // Level request to the CPU external-interrupt input
  logic        irq;

  // CPU / bench side: drives sources and accesses, observes results
  modport master (
    output src,
    output a,
    output d,
    output we,
    output rd,
    input  spo,
    input  ready,
    input  irq
  );

  // Controller side
  modport slave (
    input  src,
    input  a,
    input  d,
    input  we,
    input  rd,
    output spo,
    output ready,
    output irq
  );

endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: latches source edges into pending bits, masks with ENABLE, fixed-priority claim/complete.
// Latency: src edge -> irq after 2 clocks; register access -> spo/ready after 1 clock.
// Backpressure: none; every access is accepted and answered by a one-cycle ready pulse.
// Optional feature: define IRQ_OVERRUN_EN to build sticky per-source overrun flags at register 3.
module irq_ctrl #(
  parameter int NSRC = 4
) (
  input  logic      clk,
  input  logic      rst,
  irq_ctrl_if.slave bus
);

  // Register word map
  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_ENABLE  = 2'd1;
  localparam logic [1:0] REG_CLAIM   = 2'd2;
  localparam logic [1:0] REG_OVERRUN = 2'd3;

  // Source tracking and interrupt state
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] src_edge;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] pending_nxt;
  logic [NSRC-1:0] enable;
  logic [NSRC-1:0] cand;
  logic [4:0]      active;

  // Claim arbitration
  logic [NSRC-1:0] claim_oh;
  logic [4:0]      claim_id;
  logic            rd_claim;
  logic            claim_ok;

  // Write decode
  logic            wr_enable;
  logic            wr_complete;
  logic            complete_ok;

  // Read path and registered outputs
  logic [NSRC-1:0] ovr_rdata;
  logic [31:0]     rdata;
  logic [31:0]     spo_q;
  logic            ready_q;
  logic            irq_q;

  // Upper write-data bits beyond the source count carry no state
  logic            unused_d;
  assign unused_d = ^bus.d;

  // Rising-edge detect against the one-cycle-delayed source
  always_comb begin
    src_edge = bus.src & ~src_q;
  end

  // Only enabled, pending sources compete for a claim
  always_comb begin
    cand = pending & enable;
  end

  // Lowest-index candidate wins; scanning downward leaves the lowest set bit last
  always_comb begin
    claim_oh = '0;
    claim_id = 5'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        claim_oh    = '0;
        claim_oh[i] = 1'b1;
        claim_id    = 5'(i + 1);
      end
    end
  end

  // Access decode; a claim only takes effect with a candidate and no outstanding claim
  always_comb begin
    rd_claim    = bus.rd && (bus.a == REG_CLAIM);
    claim_ok    = rd_claim && (cand != '0) && (active == 5'd0);
    wr_enable   = bus.we && (bus.a == REG_ENABLE);
    wr_complete = bus.we && (bus.a == REG_CLAIM);
    complete_ok = wr_complete && (bus.d[4:0] == active) && (active != 5'd0);
  end

  // Claim clears its bit, but a same-cycle edge on that bit re-sets it
  always_comb begin
    pending_nxt = pending;
    if (claim_ok) begin
      pending_nxt = pending_nxt & ~claim_oh;
    end
    pending_nxt = pending_nxt | src_edge;
  end

`ifdef IRQ_OVERRUN_EN
  logic [NSRC-1:0] overrun;
  logic            rd_overrun;

  always_comb begin
    rd_overrun = bus.rd && (bus.a == REG_OVERRUN);
  end

  // Sticky overrun: edge on an already-pending bit; a read clears, but a same-cycle edge keeps it set
  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun <= '0;
    end else begin
      overrun <= (rd_overrun ? '0 : overrun) | (src_edge & pending);
    end
  end

  always_comb begin
    ovr_rdata = overrun;
  end
`else
  // No overrun storage: register 3 reads as zero
  always_comb begin
    ovr_rdata = '0;
  end
`endif

  // Read data mux, zero-extended to the bus width
  always_comb begin
    rdata = '0;
    case (bus.a)
      REG_PENDING: rdata[NSRC-1:0] = pending;
      REG_ENABLE:  rdata[NSRC-1:0] = enable;
      REG_CLAIM:   rdata[4:0]      = claim_ok ? claim_id : 5'd0;
      default:     rdata[NSRC-1:0] = ovr_rdata;
    endcase
  end

  // Source delay line and pending bits
  always_ff @(posedge clk) begin
    if (!rst) begin
      src_q   <= '0;
      pending <= '0;
    end else begin
      src_q   <= bus.src;
      pending <= pending_nxt;
    end
  end

  // Software enable mask; clearing a bit leaves pending untouched
  always_ff @(posedge clk) begin
    if (!rst) begin
      enable <= '0;
    end else if (wr_enable) begin
      enable <= bus.d[NSRC-1:0];
    end
  end

  // Outstanding claim id; claim and matching complete never coincide since we/rd are exclusive
  always_ff @(posedge clk) begin
    if (!rst) begin
      active <= 5'd0;
    end else if (claim_ok) begin
      active <= claim_id;
    end else if (complete_ok) begin
      active <= 5'd0;
    end
  end

  // Access response: spo updates only on reads, ready pulses on every access
  always_ff @(posedge clk) begin
    if (!rst) begin
      spo_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= bus.rd || bus.we;
      if (bus.rd) begin
        spo_q <= rdata;
      end
    end
  end

  // Interrupt level from current state, so it trails pending/enable/active by one clock
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (cand != '0) && (active == 5'd0);
    end
  end

  assign bus.spo   = spo_q;
  assign bus.ready = ready_q;
  assign bus.irq   = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: scoreboard of expected read data checked on each ready pulse.
// Latency: inputs driven after negedge, outputs sampled at negedge.
// Backpressure: not applicable; every access expects one ready pulse.
module tb_irq_ctrl;

  localparam int NSRC = 4;

  logic clk;
  logic rst;

  irq_ctrl_if #(.NSRC(NSRC)) bus ();

  irq_ctrl #(.NSRC(NSRC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

`ifdef IRQ_OVERRUN_EN
  localparam logic [31:0] OVR_FIRST = 32'h1;
`else
  localparam logic [31:0] OVR_FIRST = 32'h0;
`endif

  // Scoreboard: every ready pulse retires the oldest outstanding access
  always @(negedge clk) begin
    exp_t e;
    if (bus.ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL ready_unexpected: ready=1 with no access outstanding");
      end else begin
        e = sb.pop_front();
        if (e.is_rd) begin
          checks++;
          if (bus.spo !== e.data)
            $display("FAIL %s: spo=0x%0h expected 0x%0h", e.name, bus.spo, e.data);
          else
            passed++;
        end
      end
    end
  end

  // All access tasks are entered just after a negedge and return at the next one
  task automatic rd_access(input logic [1:0] addr, input logic [31:0] exp, input string nm);
    sb.push_back('{is_rd: 1'b1, data: exp, name: nm});
    bus.rd = 1'b1;
    bus.a  = addr;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  task automatic wr_access(input logic [1:0] addr, input logic [31:0] data);
    sb.push_back('{is_rd: 1'b0, data: 32'h0, name: "write"});
    bus.we = 1'b1;
    bus.a  = addr;
    bus.d  = data;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic pulse(input logic [NSRC-1:0] mask);
    bus.src = mask;
    @(negedge clk);
    bus.src = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst     = 1'b0;
    bus.src = '0;
    bus.a   = 2'd0;
    bus.d   = 32'h0;
    bus.we  = 1'b0;
    bus.rd  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.irq !== 1'b0) $display("FAIL reset_irq: irq=%b expected 0", bus.irq); else passed++;
    checks++;
    if (bus.spo !== 32'h0) $display("FAIL reset_spo: spo=0x%0h expected 0x0", bus.spo); else passed++;
    checks++;
    if (bus.ready !== 1'b0) $display("FAIL reset_ready: ready=%b expected 0", bus.ready); else passed++;
    rd_access(2'd0, 32'h0, "reset_pending");
    rd_access(2'd1, 32'h0, "reset_enable");
    tick(1);
  endtask

  task automatic test_basic;
    wr_access(2'd1, 32'h1);
    pulse(4'b0001);
    checks++;
    if (bus.irq !== 1'b0) $display("FAIL basic_irq_latency: irq=%b expected 0", bus.irq); else passed++;
    tick(1);
    checks++;
    if (bus.irq !== 1'b1) $display("FAIL basic_irq_rise: irq=%b expected 1", bus.irq); else passed++;
    rd_access(2'd0, 32'h1, "basic_pending");
    rd_access(2'd2, 32'h1, "basic_claim");
    checks++;
    if (bus.irq !== 1'b1) $display("FAIL basic_irq_hold: irq=%b expected 1", bus.irq); else passed++;
    tick(1);
    checks++;
    if (bus.irq !== 1'b0) $display("FAIL basic_irq_fall: irq=%b expected 0", bus.irq); else passed++;
    wr_access(2'd2, 32'h1);
    tick(2);
    checks++;
    if (bus.irq !== 1'b0) $display("FAIL basic_after_complete: irq=%b expected 0", bus.irq); else passed++;
  endtask

  task automatic test_priority;
    wr_access(2'd1, 32'hF);
    pulse(4'b1010);
    tick(1);
    checks++;
    if (bus.irq !== 1'b1) $display("FAIL prio_irq: irq=%b expected 1", bus.irq); else passed++;
    rd_access(2'd2, 32'h2, "prio_claim_first");
    rd_access(2'd2, 32'h0, "prio_claim_nested");
    wr_access(2'd2, 32'h2);
    rd_access(2'd2, 32'h4, "prio_claim_second");
    wr_access(2'd2, 32'h4);
    tick(2);
    checks++;
    if (bus.irq !== 1'b0) $display("FAIL prio_idle: irq=%b expected 0", bus.irq); else passed++;
  endtask

  task automatic test_disabled;
    wr_access(2'd1, 32'h0);
    pulse(4'b0100);
    tick(2);
    checks++;
    if (bus.irq !== 1'b0) $display("FAIL dis_irq_masked: irq=%b expected 0", bus.irq); else passed++;
    rd_access(2'd0, 32'h4, "dis_pending");
    wr_access(2'd1, 32'h4);
    checks++;
    if (bus.irq !== 1'b0) $display("FAIL dis_irq_early: irq=%b expected 0", bus.irq); else passed++;
    tick(1);
    checks++;
    if (bus.irq !== 1'b1) $display("FAIL dis_irq_enabled: irq=%b expected 1", bus.irq); else passed++;
    rd_access(2'd2, 32'h3, "dis_claim");
    wr_access(2'd2, 32'h3);
    tick(1);
  endtask

  task automatic test_bad_complete;
    wr_access(2'd1, 32'h1);
    pulse(4'b0001);
    tick(1);
    rd_access(2'd2, 32'h1, "bad_claim");
    wr_access(2'd2, 32'h3);
    pulse(4'b0001);
    tick(2);
    checks++;
    if (bus.irq !== 1'b0) $display("FAIL bad_irq_held: irq=%b expected 0", bus.irq); else passed++;
    rd_access(2'd2, 32'h0, "bad_still_active");
    wr_access(2'd2, 32'h1);
    checks++;
    if (bus.irq !== 1'b0) $display("FAIL bad_irq_early: irq=%b expected 0", bus.irq); else passed++;
    tick(1);
    checks++;
    if (bus.irq !== 1'b1) $display("FAIL bad_irq_reassert: irq=%b expected 1", bus.irq); else passed++;
    rd_access(2'd2, 32'h1, "bad_reclaim");
    wr_access(2'd2, 32'h1);
    tick(1);
  endtask

  task automatic test_overrun;
    wr_access(2'd1, 32'h0);
    pulse(4'b0001);
    tick(4);
    pulse(4'b0001);
    tick(1);
    rd_access(2'd3, OVR_FIRST, "ovr_first_read");
    rd_access(2'd3, 32'h0, "ovr_second_read");
    rd_access(2'd2, 32'h0, "ovr_claim_disabled");
    wr_access(2'd1, 32'h1);
    rd_access(2'd2, 32'h1, "ovr_claim");
    wr_access(2'd2, 32'h1);
    tick(1);
  endtask

  task automatic test_back_to_back;
    pulse(4'b0001);
    tick(1);
    // Claim in the same cycle as a fresh edge on the claimed bit
    sb.push_back('{is_rd: 1'b1, data: 32'h1, name: "b2b_claim_collide"});
    bus.rd  = 1'b1;
    bus.a   = 2'd2;
    bus.src = 4'b0001;
    @(negedge clk);
    bus.rd  = 1'b0;
    bus.src = '0;
    rd_access(2'd0, 32'h1, "b2b_pending_kept");
    rd_access(2'd2, 32'h0, "b2b_claim_active");
    wr_access(2'd2, 32'h1);
    rd_access(2'd2, 32'h1, "b2b_claim_again");
    wr_access(2'd2, 32'h1);
    rd_access(2'd0, 32'h0, "b2b_pending_empty");
    tick(2);
    checks++;
    if (bus.irq !== 1'b0) $display("FAIL b2b_idle: irq=%b expected 0", bus.irq); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_disabled();
    test_bad_complete();
    test_overrun();
    test_back_to_back();
    tick(3);
    checks++;
    if (sb.size() != 0) $display("FAIL sb_drain: outstanding=%0d expected 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Hard stop in case the sequence itself stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past time limit");
    $fatal(1, "timeout");
  end

endmodule
